load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle data-memory access unit sitting directly downstream of the core controller: it takes the controller's memory request (address, write enable, write data, funct3 size/sign code) and runs a valid/ready transaction on the data bus. It handles byte-lane steering, byte strobes and misalignment checking, and returns load data already right-aligned and extended. While an access is in flight, the core holds PC and register-file writes via `stall`.

## Interface
Parameters:
- none; data and address widths are fixed at 32.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: controller issues a load or store; held stable until `done`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I size code (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `req_addr` in 32: byte address (ALU result).
- `req_wd` in 32: store data, taken from rs2.
- `stall` out 1: `req_valid & ~done`, combinational.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `done`; misaligned access, illegal funct3, or bus error.
- `rd_data` out 32: load result, valid with `done`; 0 for stores and on fault.
- `bus_valid` out 1, `bus_ready` in 1: request handshake.
- `bus_we` out 1; `bus_addr` out 32 (bits [1:0] always 0); `bus_wstrb` out 4; `bus_wdata` out 32.
- `bus_rvalid` in 1, `bus_rdata` in 32, `bus_err` in 1: response, one per request, for both loads and stores.

## Operation
- FSM states are IDLE, REQ, RESP and DONE.
- IDLE, `req_valid`=1: register we, funct3, addr[1:0] and lane-steered write data.
  - Illegal or misaligned access → DONE with fault.
  - Otherwise → REQ.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠0.
- REQ: `bus_valid`=1, all bus outputs stable; on `bus_ready` → RESP.
- RESP: wait for `bus_rvalid`, then register the result and error → DONE.
  - `bus_rvalid` seen in any other state is ignored.
- DONE: `done`=1 → IDLE.
- Stores, lane steering:
  - sb: `wstrb`=0001<<a, `wdata`={4{wd[7:0]}}.
  - sh: `wstrb`=0011<<a, `wdata`={2{wd[15:0]}}.
  - sw: `wstrb`=1111, `wdata`=wd.
  - Here a = addr[1:0].
- Loads: `wstrb`=0000. Shift `bus_rdata` right by 8·a, then sign- or zero-extend from bit 7 or 15 per funct3.
- `bus_err`=1 → `fault`=1, `rd_data`=0.

## Timing
- Reset values: state IDLE; `done`, `fault`, `bus_valid`, `bus_we` = 0; `rd_data`, `bus_addr`, `bus_wstrb`, `bus_wdata` = 0.
- Zero-wait bus (`bus_ready` and `bus_rvalid` each high one cycle after the previous step):
  - Accept at cycle 0, `bus_valid` at cycle 1, `bus_rvalid` at cycle 2, `done` at cycle 3.
- Each cycle of `bus_ready`=0 or late `bus_rvalid` adds one cycle.
- Fault from misalignment or illegal funct3: `done`+`fault` at cycle 1; no bus request is issued.
- `bus_rvalid` in the same cycle as the `bus_ready` handshake is not legal bus behaviour. RESP is entered only on the following cycle.
- Back-to-back accesses: a new request is accepted in the IDLE cycle after DONE (4 cycles/access minimum).
- Reset mid-operation: return to IDLE immediately, drop `bus_valid`, discard any later response.
- `req_*` changing while not in IDLE is ignored; all values used come from registers.

## Structure
- Add `mem_size_e` (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU, encoded as funct3) to the shared types package.
- The FSM state enum stays local to the module.
- Sub-module `lsu_align`: purely combinational.
  - Inputs: size, a, wd, rdata.
  - Outputs: wstrb, wdata, rdata-extended, misaligned, illegal.

## Test plan
- lw at 0x100, bus returns 0xDEADBEEF with zero wait → `bus_addr`=0x100, `wstrb`=0, `done` at cycle 3, `rd_data`=0xDEADBEEF, `fault`=0.
- lb / lbu at 0x103, `bus_rdata`=0x80FF0102 → `rd_data`=0xFFFFFF80 and 0x00000080.
- sh at 0x202, `req_wd`=0x0000ABCD → `bus_addr`=0x200, `wstrb`=1100, `wdata`=0xABCDABCD, `bus_we`=1.
- lw at 0x101, and store with funct3=100 → `done`+`fault` at cycle 1, `bus_valid` never asserted.
- sb with `bus_ready` low for 3 cycles, then `bus_err`=1 → bus outputs stable across the wait, `fault`=1, `done` at cycle 6.
- `rst_n` pulsed low while in RESP, then `bus_rvalid` arrives → all outputs 0, no `done`, next request serviced normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit.
// mem_size_e: RV32I load/store size codes, encoded exactly as funct3.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering and load extension for the load/store unit.
// Ports:
//   we         : 1 = store, 0 = load (store accepts fewer size codes)
//   size       : funct3 size code (may be an illegal value)
//   a          : byte offset within the word (addr[1:0])
//   wd         : raw store data from rs2
//   rdata      : raw word returned by the bus
//   wstrb      : byte strobes (0 for loads)
//   wdata      : lane-replicated store data (0 for loads)
//   rdata_ext  : load data shifted down by the offset and sign/zero extended
//   misaligned : halfword at odd address or word not on a 4-byte boundary
//   illegal    : size code not valid for this access direction
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    assign shifted = rdata >> {a, 3'b000};

    always_comb begin
        wstrb      = 4'b0000;
        wdata      = 32'h0;
        rdata_ext  = 32'h0;
        misaligned = 1'b0;
        illegal    = 1'b0;

        case (size)
            MEM_B:  begin
                rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
                wstrb     = we ? (4'b0001 << a) : 4'b0000;
                wdata     = we ? {4{wd[7:0]}} : 32'h0;
            end
            MEM_H:  begin
                rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
                wstrb      = we ? (4'b0011 << a) : 4'b0000;
                wdata      = we ? {2{wd[15:0]}} : 32'h0;
                misaligned = a[0];
            end
            MEM_W:  begin
                rdata_ext  = shifted;
                wstrb      = we ? 4'b1111 : 4'b0000;
                wdata      = we ? wd : 32'h0;
                misaligned = (a != 2'b00);
            end
            MEM_BU: begin
                rdata_ext = {24'h0, shifted[7:0]};
                illegal   = we;
            end
            MEM_HU: begin
                rdata_ext  = {16'h0, shifted[15:0]};
                misaligned = a[0];
                illegal    = we;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access unit. Accepts one load/store request from the
// core controller, runs a valid/ready request plus one response on the data bus,
// and returns aligned, extended load data with a one-cycle done pulse.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   req_valid/we/funct3/addr/wd     : controller request, held until done
//   stall                           : req_valid & ~done
//   done, fault, rd_data            : completion pulse, error flag, load result
//   bus_valid/ready                 : bus request handshake
//   bus_we/addr/wstrb/wdata         : bus request payload (word aligned)
//   bus_rvalid/rdata/err            : bus response
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wd,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] rd_data,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  a_q, a_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        in_idle;
    logic        al_we;
    logic [2:0]  al_size;
    logic [1:0]  al_a;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misaligned;
    logic        al_illegal;

    // In IDLE the aligner checks/steers the live request; afterwards it works
    // from the captured request so later changes on req_* have no effect.
    assign in_idle = (state_q == StIdle);
    assign al_we   = in_idle ? req_we : bus_we_q;
    assign al_size = in_idle ? req_funct3 : funct3_q;
    assign al_a    = in_idle ? req_addr[1:0] : a_q;

    lsu_align u_align (
        .we         (al_we),
        .size       (al_size),
        .a          (al_a),
        .wd         (req_wd),
        .rdata      (bus_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        a_d         = a_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        rd_data_d   = 32'h0;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_wdata_d = bus_wdata_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    a_d      = req_addr[1:0];
                    bus_we_d = req_we;
                    if (al_misaligned || al_illegal) begin
                        // Rejected locally: complete next cycle, no bus traffic.
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        bus_valid_d = 1'b1;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_wstrb_d = al_wstrb;
                        bus_wdata_d = al_wdata;
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (bus_rvalid) begin
                    done_d    = 1'b1;
                    fault_d   = bus_err;
                    rd_data_d = (bus_err || bus_we_q) ? 32'h0 : al_rdata;
                    state_d   = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            funct3_q    <= 3'b000;
            a_q         <= 2'b00;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            rd_data_q   <= 32'h0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wstrb_q <= 4'b0000;
            bus_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            a_q         <= a_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            rd_data_q   <= rd_data_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign stall     = req_valid & ~done_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign rd_data   = rd_data_q;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wd;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] rd_data;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wd     (req_wd),
        .stall      (stall),
        .done       (done),
        .fault      (fault),
        .rd_data    (rd_data),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        err;
        int          delay;
        int          exp_cyc;
        logic        exp_fault;
        logic [31:0] exp_rd;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One access: the bench plays the bus, waiting v.delay cycles before ready,
    // answering with rvalid on the cycle after the handshake.
    task automatic run_vec(input vec_t v, input string tag);
        int          cyc_done = -1;
        int          nvalid   = 0;
        int          waited   = 0;
        logic        hs       = 1'b0;
        logic        stable   = 1'b1;
        logic        stall1   = 1'b0;
        logic        fault_s  = 1'b0;
        logic [31:0] rd_s     = 32'h0;
        logic        we0      = 1'b0;
        logic [31:0] a0       = 32'h0;
        logic [31:0] d0       = 32'h0;
        logic [3:0]  s0       = 4'h0;

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wd     = v.wd;
        @(posedge clk);
        #1;
        // Scramble the request after acceptance; the unit must ignore it.
        req_we     = ~v.we;
        req_funct3 = v.f3 ^ 3'b111;
        req_addr   = ~v.addr;
        req_wd     = ~v.wd;

        for (int k = 1; k <= 40 && cyc_done < 0; k++) begin
            @(negedge clk);
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
            bus_err    = 1'b0;
            if (k == 1) stall1 = stall;
            if (done) begin
                cyc_done = k;
                fault_s  = fault;
                rd_s     = rd_data;
                check({tag, " stall_at_done"}, {31'h0, stall}, 32'h0);
                req_valid = 1'b0;
            end
            if (bus_valid) begin
                if (nvalid == 0) begin
                    we0 = bus_we; a0 = bus_addr; d0 = bus_wdata; s0 = bus_wstrb;
                end else if (bus_we !== we0 || bus_addr !== a0 || bus_wdata !== d0 ||
                             bus_wstrb !== s0) begin
                    stable = 1'b0;
                end
                nvalid++;
                if (waited < v.delay) waited++;
                else begin
                    bus_ready = 1'b1;
                    hs        = 1'b1;
                end
            end else if (hs) begin
                bus_rvalid = 1'b1;
                bus_rdata  = v.rdata;
                bus_err    = v.err;
                hs         = 1'b0;
            end
        end
        req_valid = 1'b0;

        check({tag, " done_cycle"}, cyc_done, v.exp_cyc);
        check({tag, " fault"}, {31'h0, fault_s}, {31'h0, v.exp_fault});
        check({tag, " rd_data"}, rd_s, v.exp_rd);
        check({tag, " stall_cycle1"}, {31'h0, stall1}, {31'h0, (v.exp_cyc != 1)});
        if (v.exp_cyc == 1) begin
            check({tag, " bus_valid_count"}, nvalid, 0);
        end else begin
            check({tag, " bus_valid_count"}, nvalid, v.delay + 1);
            check({tag, " bus_addr"}, a0, v.exp_baddr);
            check({tag, " bus_wstrb"}, {28'h0, s0}, {28'h0, v.exp_wstrb});
            check({tag, " bus_wdata"}, d0, v.exp_wdata);
            check({tag, " bus_we"}, {31'h0, we0}, {31'h0, v.we});
            check({tag, " bus_stable"}, {31'h0, stable}, 32'h1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " done"}, {31'h0, done}, 32'h0);
        check({tag, " fault"}, {31'h0, fault}, 32'h0);
        check({tag, " rd_data"}, rd_data, 32'h0);
        check({tag, " bus_valid"}, {31'h0, bus_valid}, 32'h0);
        check({tag, " bus_we"}, {31'h0, bus_we}, 32'h0);
        check({tag, " bus_addr"}, bus_addr, 32'h0);
        check({tag, " bus_wstrb"}, {28'h0, bus_wstrb}, 32'h0);
        check({tag, " bus_wdata"}, bus_wdata, 32'h0);
    endtask

    initial begin
        logic spurious;

        //         we    f3      addr          wd            rdata         err  dly cyc flt   exp_rd        baddr         strb     wdata
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 0, 3, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 4'b0000, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0102, 1'b0, 0, 3, 1'b0, 32'hFFFF_FF80, 32'h0000_0100, 4'b0000, 32'h0};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0102, 1'b0, 0, 3, 1'b0, 32'h0000_0080, 32'h0000_0100, 4'b0000, 32'h0};
        vecs[3]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 1'b0, 0, 3, 1'b0, 32'hFFFF_8001, 32'h0000_0100, 4'b0000, 32'h0};
        vecs[4]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_1234, 1'b0, 1, 4, 1'b0, 32'h0000_8001, 32'h0000_0100, 4'b0000, 32'h0};
        vecs[5]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h1234_8756, 1'b0, 0, 3, 1'b0, 32'hFFFF_FF87, 32'h0000_0100, 4'b0000, 32'h0};
        vecs[6]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'hFFFF_FFFF, 1'b0, 0, 3, 1'b0, 32'h0,        32'h0000_0200, 4'b1100, 32'hABCD_ABCD};
        vecs[7]  = '{1'b1, 3'b000, 32'h0000_0301, 32'h1234_56EF, 32'hFFFF_FFFF, 1'b0, 0, 3, 1'b0, 32'h0,        32'h0000_0300, 4'b0010, 32'hEFEF_EFEF};
        vecs[8]  = '{1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0, 0, 3, 1'b0, 32'h0,        32'h0000_0400, 4'b1111, 32'hCAFE_F00D};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h1111_1111, 1'b0, 0, 1, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[10] = '{1'b1, 3'b100, 32'h0000_0100, 32'h5555_5555, 32'h1111_1111, 1'b0, 0, 1, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[11] = '{1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h1111_1111, 1'b0, 0, 1, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[12] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h1111_1111, 1'b0, 0, 1, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[13] = '{1'b1, 3'b000, 32'h0000_0302, 32'h0000_007A, 32'h2222_2222, 1'b1, 3, 6, 1'b1, 32'h0,        32'h0000_0300, 4'b0100, 32'h7A7A_7A7A};
        vecs[14] = '{1'b0, 3'b010, 32'h0000_0500, 32'h0,        32'h3333_3333, 1'b1, 0, 3, 1'b1, 32'h0,        32'h0000_0500, 4'b0000, 32'h0};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wd     = 32'h0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        bus_err    = 1'b0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while waiting for the response; the late response must be dropped.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0600;
        @(negedge clk);
        check("rst_seq bus_valid", {31'h0, bus_valid}, 32'h1);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_all_zero("rst_seq");
        req_valid = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h9999_9999;
        spurious   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            if (done || bus_valid || fault || rd_data != 32'h0) spurious = 1'b1;
        end
        check("rst_seq no_done_after_reset", {31'h0, spurious}, 32'h0);
        run_vec(vecs[0], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
